conv_feature_engine: RTL
========================

# conv_feature_engine

Parametrised, time-multiplexed 2-D convolution engine for the FSRCNN feature-extraction layer. It takes one NUM_CHANNELS×KERNEL_SIZE×KERNEL_SIZE input window and produces NUM_FILTERS output feature values, one filter at a time. Each value goes through bias add, rounding, saturation and optional ReLU. It sits between the window line-buffer and the shrinking layer. Weights and biases are loaded at run time through a write port, so changing the kernels needs no re-synthesis.

## Interface
- KERNEL_SIZE, 5, kernel edge length K.
- NUM_FILTERS, 48, output features per window F.
- NUM_CHANNELS, 1, input channels C.
- DATA_W, 8, signed pixel width.
- COEF_W, 16, signed weight/bias width.
- FRAC_BITS, 12, fractional bits of weights; output shift amount; must be ≥1.
- OUT_W, 16, signed output width.
- RELU, 1, 1 = clamp negative results to 0.
- Derived: N = C·K·K; ACC_W = DATA_W+COEF_W+clog2(N)+1.
- clk_in  in  1  single clock, rising edge.
- rst_in  in  1  synchronous, active-high reset.
- start  in  1  request to process map_in; accepted only when ready=1.
- map_in  in  N·DATA_W  window; element (c,r,col) at index i=(c·K+r)·K+col, bits [i·DATA_W +: DATA_W].
- coef_we  in  1  weight write strobe.
- coef_addr  in  clog2(F·N)  weight address = f·N + i.
- coef_data  in  COEF_W  signed weight.
- bias_we  in  1  bias write strobe.
- bias_addr  in  clog2(F)  filter index.
- bias_data  in  COEF_W  signed bias, FRAC_BITS fractional bits.
- out_ready  in  1  downstream accepts map_out.
- map_out  out  OUT_W  signed result for filter map_out_idx.
- map_out_idx  out  clog2(F)  filter index of map_out.
- save  out  1  map_out valid; held until out_ready.
- ready  out  1  idle, can accept start.
- done  out  1  one-cycle pulse after the last filter's handshake.

## Operation
- FSM: IDLE → MAC → ROUND → OUT → (MAC for the next filter | IDLE).
- IDLE: ready=1.
  - Sets of start=1 register map_in, set f=0, row=0, acc = sign-extended bias[0], then go to MAC.
- MAC: one row per cycle. acc += Σ_col pix(c,r,col)·w(f,c,r,col) over the K columns. That is K signed multipliers; row counts over C·K rows.
  - After row C·K−1 is accumulated, go to ROUND.
- ROUND: v = (acc + 2^(FRAC_BITS−1)) >>> FRAC_BITS, i.e. arithmetic shift, round half up.
  - Saturate v to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
  - If RELU=1 and v<0, v=0.
  - Register map_out=v and map_out_idx=f; set save=1; go to OUT.
- OUT: hold save, map_out and map_out_idx stable while out_ready=0.
  - On save&out_ready: save=0.
  - If f=F−1: done=1 next cycle and return to IDLE.
  - Else: f++, acc = bias[f+1], row=0, go to MAC.
- Coef/bias writes are honoured only when ready=1 and start=0. Writes at any other time are dropped.
- The latched window is unaffected by map_in changes while busy.
- start while ready=0 is ignored (not queued).
- Accumulator is ACC_W bits and never overflows.

## Timing
- Reset values: save=0, done=0, ready=1, map_out=0, map_out_idx=0; state=IDLE.
- Reset does not clear the coef or bias memories.
- Reset asserted in any state aborts the window with no partial output. ready=1 on the cycle after the reset edge.
- Start accepted at edge E0. MAC occupies edges E1..E(C·K); ROUND at E(C·K+1); save is high after that edge.
- Per filter, with out_ready=1: C·K+2 cycles.
- Window total: F·(C·K+2) cycles, e.g. 336 for the defaults.
- done is high for exactly one cycle, starting the cycle after the final handshake. ready rises in the same cycle as done.
- Each cycle out_ready is low while save=1 adds exactly one cycle. No result is dropped or duplicated.

## Test plan
- Identity, defaults:
  - Stimulus: filter 0 has coef[12]=0x1000 and all else 0; other filters are all zero; all biases 0; centre pixel 37, others random.
  - Response: idx0 → 37, idx1..47 → 0; done exactly 336 cycles after start.
- Rounding/ReLU:
  - Stimulus: all weights 0, bias 0x0800.
  - Response: all outputs 1.
  - With bias −0x0800 and RELU=0: 0. With bias −0x2000: RELU=0 → −2, RELU=1 → 0.
- Saturation, OUT_W=8:
  - Stimulus: all pixels 127, weights 0x7FFF.
  - Response: 127. With pixels −128 and RELU=0: −128.
- Multichannel, C=3:
  - Stimulus: weights 0x1000 only on channel-2 centre; that pixel is −5; RELU=0.
  - Response: −5; first save 16 cycles after start.
- Backpressure:
  - Stimulus: out_ready low for 10 cycles while idx=3 is presented.
  - Response: map_out and idx stable throughout; indices 0..47 appear in order; done at 346 cycles.
- Illegal/abort:
  - Stimulus: start and coef writes while busy; then rst_in mid-MAC, followed by a fresh start.
  - Response: busy-time writes and start have no effect on results; after reset save=0 and ready=1; the next window gives the full correct sequence.

Source files
------------

// File: rtl/conv_feature_engine_if.sv
// Handshake/bus bundle for conv_feature_engine.
// master: window source / coefficient loader / result consumer.
// slave : the convolution engine.
// Signals: start/map_in (window request), coef_* and bias_* (run-time
// kernel load), out_ready/map_out/map_out_idx/save (result handshake),
// ready (idle), done (end-of-window pulse).
interface conv_feature_engine_if #(
  parameter int KERNEL_SIZE  = 5,
  parameter int NUM_FILTERS  = 48,
  parameter int NUM_CHANNELS = 1,
  parameter int DATA_W       = 8,
  parameter int COEF_W       = 16,
  parameter int OUT_W        = 16
);
  localparam int N  = NUM_CHANNELS * KERNEL_SIZE * KERNEL_SIZE;
  localparam int AW = (NUM_FILTERS * N > 1) ? $clog2(NUM_FILTERS * N) : 1;
  localparam int FW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;

  logic                     start;
  logic [N*DATA_W-1:0]      map_in;
  logic                     coef_we;
  logic [AW-1:0]            coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic                     bias_we;
  logic [FW-1:0]            bias_addr;
  logic signed [COEF_W-1:0] bias_data;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  map_out;
  logic [FW-1:0]            map_out_idx;
  logic                     save;
  logic                     ready;
  logic                     done;

  modport master (
    output start, map_in, coef_we, coef_addr, coef_data,
           bias_we, bias_addr, bias_data, out_ready,
    input  map_out, map_out_idx, save, ready, done
  );

  modport slave (
    input  start, map_in, coef_we, coef_addr, coef_data,
           bias_we, bias_addr, bias_data, out_ready,
    output map_out, map_out_idx, save, ready, done
  );
endinterface

// File: rtl/conv_feature_engine.sv
// Time-multiplexed 2-D convolution engine (FSRCNN feature extraction).
// One C x K x K window in, NUM_FILTERS results out, one filter at a time:
// K signed MACs per cycle (one kernel row), then bias-included round,
// saturate and optional ReLU, then a valid/ready output handshake.
// Ports: clk_in (rising edge), rst_in (synchronous, active high),
//        bus (slave side of conv_feature_engine_if).
// Weight/bias memories are not reset; they are written only while idle
// and no start is being presented.
module conv_feature_engine #(
  parameter int KERNEL_SIZE  = 5,
  parameter int NUM_FILTERS  = 48,
  parameter int NUM_CHANNELS = 1,
  parameter int DATA_W       = 8,
  parameter int COEF_W       = 16,
  parameter int FRAC_BITS    = 12,
  parameter int OUT_W        = 16,
  parameter int RELU         = 1
) (
  input logic                   clk_in,
  input logic                   rst_in,
  conv_feature_engine_if.slave  bus
);
  localparam int N     = NUM_CHANNELS * KERNEL_SIZE * KERNEL_SIZE;
  localparam int ROWS  = NUM_CHANNELS * KERNEL_SIZE;
  localparam int ACC_W = DATA_W + COEF_W + $clog2(N) + 1;
  localparam int PW    = DATA_W + COEF_W;
  localparam int AW    = (NUM_FILTERS * N > 1) ? $clog2(NUM_FILTERS * N) : 1;
  localparam int FW    = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;

  // Rounding and saturation are evaluated one bit wider than the accumulator
  // so the half-LSB add can never wrap.
  localparam logic signed [ACC_W:0] RND_HALF = (ACC_W+1)'(64'd1 << (FRAC_BITS - 1));
  localparam logic signed [ACC_W:0] OUT_MAX  = (ACC_W+1)'((64'd1 << (OUT_W - 1)) - 64'd1);
  localparam logic signed [ACC_W:0] OUT_MIN  = ~OUT_MAX;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_ROUND, S_OUT} state_e;

  state_e                   state_q, state_d;
  logic [N*DATA_W-1:0]      win_q, win_d;
  logic [FW-1:0]            f_q, f_d;
  logic [RW-1:0]            row_q, row_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [OUT_W-1:0]  map_out_q, map_out_d;
  logic [FW-1:0]            idx_q, idx_d;
  logic                     save_q, save_d;
  logic                     done_q, done_d;

  logic signed [COEF_W-1:0] coef_mem_q [NUM_FILTERS*N];
  logic signed [COEF_W-1:0] bias_mem_q [NUM_FILTERS];

  logic                     cfg_open;
  logic [FW-1:0]            f_nxt;

  logic signed [DATA_W-1:0] pix_w  [KERNEL_SIZE];
  logic signed [COEF_W-1:0] wt_w   [KERNEL_SIZE];
  logic signed [PW-1:0]     prod_w [KERNEL_SIZE];
  logic signed [ACC_W-1:0]  row_sum;

  logic signed [ACC_W:0]    rnd_sum;
  logic signed [ACC_W:0]    rnd_shift;
  logic signed [OUT_W-1:0]  sat_val;

  assign cfg_open = (state_q == S_IDLE) && !bus.start;
  assign f_nxt    = f_q + 1'b1;

  always_ff @(posedge clk_in) begin
    if (cfg_open && bus.coef_we && (int'(bus.coef_addr) < NUM_FILTERS * N)) begin
      coef_mem_q[bus.coef_addr] <= bus.coef_data;
    end
    if (cfg_open && bus.bias_we && (int'(bus.bias_addr) < NUM_FILTERS)) begin
      bias_mem_q[bus.bias_addr] <= bus.bias_data;
    end
  end

  // One kernel row per cycle: K products of the current row against the
  // current filter's weights.
  always_comb begin
    row_sum = '0;
    for (int unsigned col = 0; col < KERNEL_SIZE; col++) begin
      int unsigned pi;
      pi          = int'(row_q) * KERNEL_SIZE + col;
      pix_w[col]  = win_q[pi*DATA_W +: DATA_W];
      wt_w[col]   = coef_mem_q[AW'(int'(f_q) * N + pi)];
      prod_w[col] = PW'(pix_w[col]) * PW'(wt_w[col]);
      row_sum     = row_sum + ACC_W'(prod_w[col]);
    end
  end

  always_comb begin
    rnd_sum   = (ACC_W+1)'(acc_q) + RND_HALF;
    rnd_shift = rnd_sum >>> FRAC_BITS;
    if (rnd_shift > OUT_MAX) begin
      sat_val = OUT_W'(OUT_MAX);
    end else if (rnd_shift < OUT_MIN) begin
      sat_val = OUT_W'(OUT_MIN);
    end else begin
      sat_val = OUT_W'(rnd_shift);
    end
    if ((RELU != 0) && rnd_shift[ACC_W]) begin
      sat_val = '0;
    end
  end

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    f_d       = f_q;
    row_d     = row_q;
    acc_d     = acc_q;
    map_out_d = map_out_q;
    idx_d     = idx_q;
    save_d    = save_q;
    done_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          win_d   = bus.map_in;
          f_d     = '0;
          row_d   = '0;
          acc_d   = ACC_W'(bias_mem_q[0]);
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_q + row_sum;
        row_d = row_q + 1'b1;
        if (row_q == RW'(ROWS - 1)) begin
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        map_out_d = sat_val;
        idx_d     = f_q;
        save_d    = 1'b1;
        state_d   = S_OUT;
      end
      S_OUT: begin
        if (bus.out_ready) begin
          save_d = 1'b0;
          if (f_q == FW'(NUM_FILTERS - 1)) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            f_d     = f_nxt;
            row_d   = '0;
            acc_d   = ACC_W'(bias_mem_q[f_nxt]);
            state_d = S_MAC;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= S_IDLE;
      win_q     <= '0;
      f_q       <= '0;
      row_q     <= '0;
      acc_q     <= '0;
      map_out_q <= '0;
      idx_q     <= '0;
      save_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      f_q       <= f_d;
      row_q     <= row_d;
      acc_q     <= acc_d;
      map_out_q <= map_out_d;
      idx_q     <= idx_d;
      save_q    <= save_d;
      done_q    <= done_d;
    end
  end

  assign bus.map_out     = map_out_q;
  assign bus.map_out_idx = idx_q;
  assign bus.save        = save_q;
  assign bus.ready       = (state_q == S_IDLE);
  assign bus.done        = done_q;
endmodule
